// File: rtl/bf_pkg.sv
// bf_pkg: shared types and defaults for the Brainfuck output path
package bf_pkg;
  typedef logic [7:0] char_t;
  localparam int BF_FIFO_DEPTH = 16;
  localparam int BF_SYNC_STAGES = 2;
endpackage

// File: rtl/strobe_edge_sync.sv
// strobe_edge_sync: N-flop synchroniser (reset to 1) with one-cycle rising-edge pulse
module strobe_edge_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);
  logic [N:0] s;
  // Shift chain; top bit keeps the previous value of the last stage for edge detect
  always_ff @(posedge clk or posedge rst)
    if (rst) s <= '1;
    else s <= {s[N-1:0], d};
  assign pulse = s[N-1] & ~s[N];
endmodule

// File: rtl/bf_char_fifo.sv
// bf_char_fifo: captures core output strobes into a FIFO and presents them over valid/ready
module bf_char_fifo
  import bf_pkg::*;
#(
  parameter int DEPTH = BF_FIFO_DEPTH,
  parameter int SYNC_STAGES = BF_SYNC_STAGES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_strobe,
  input  char_t                    wr_char,
  output char_t                    out_char,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  char_t mem [DEPTH];
  logic [AW-1:0] wptr, rptr, rd_addr;
  logic push_req, push, pop, valid_nx, load;
  strobe_edge_sync #(.N(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .d(wr_strobe),
    .pulse(push_req)
  );
  assign full = level == (AW+1)'(DEPTH);
  assign pop = out_valid & out_ready;
  assign push = push_req & (~full | pop);
  // A pop of the last stored entry drops valid; a fresh entry becomes visible one cycle after it lands
  always_comb begin
    valid_nx = pop ? (level > (AW+1)'(1)) : (level != '0);
    load = valid_nx & (pop | ~out_valid);
    rd_addr = pop ? rptr + 1'b1 : rptr;
  end
  // Storage array, no reset so it maps onto distributed RAM
  always_ff @(posedge clk)
    if (push) mem[wptr] <= wr_char;
  // Pointers, occupancy, sticky overflow and the registered head-of-queue read
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
      overflow <= 1'b0;
      out_valid <= 1'b0;
      out_char <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
      overflow <= overflow | (push_req & ~push);
      out_valid <= valid_nx;
      if (load) out_char <= mem[rd_addr];
    end
endmodule

// File: tb/tb_bf_char_fifo.sv
// tb_bf_char_fifo: randomized and directed checks of bf_char_fifo against a queue-based model
module tb_bf_char_fifo;
  localparam int D = 16;
  localparam int N = 2;
  logic clk = 0, rst = 1, wr_strobe = 1, out_ready = 0;
  logic [7:0] wr_char = 0, out_char;
  logic out_valid, full, overflow;
  logic [4:0] level;
  int vecs = 0, errs = 0;
  bit rnd = 0;
  byte unsigned q[$];
  logic ov_m, of_m;
  logic [7:0] hold_m;
  logic [N+1:0] h;
  bit pop_m, push_m;
  int n_m;
  logic [7:0] hello [5] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};

  always #5 clk = ~clk;

  bf_char_fifo #(.DEPTH(D), .SYNC_STAGES(N)) dut (
    .clk(clk),
    .rst(rst),
    .wr_strobe(wr_strobe),
    .wr_char(wr_char),
    .out_char(out_char),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level(level),
    .full(full),
    .overflow(overflow)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [7:0] c);
    wr_char = c;
    wr_strobe = 1;
    repeat (4) tick();
    wr_strobe = 0;
    repeat (4) tick();
  endtask

  // Reference: strobe seen N+1 edges late, queue of stored chars, head shown per handshake rules
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      ov_m = 0;
      of_m = 0;
      hold_m = 0;
      h = '1;
    end else begin
      h = {h[N:0], wr_strobe};
      push_m = h[N] && !h[N+1];
      pop_m = ov_m && out_ready;
      n_m = q.size();
      if (pop_m) void'(q.pop_front());
      if (push_m && (n_m < D || pop_m)) q.push_back(wr_char);
      else if (push_m) of_m = 1;
      ov_m = pop_m ? (n_m > 1) : (n_m > 0);
      if (ov_m) hold_m = q[0];
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_char", 32'(out_char), 0);
      chk("rst_level", 32'(level), 0);
      chk("rst_full", 32'(full), 0);
      chk("rst_ovf", 32'(overflow), 0);
    end else begin
      chk("valid", 32'(out_valid), 32'(ov_m));
      chk("char", 32'(out_char), ov_m ? 32'(q[0]) : 32'(hold_m));
      chk("level", 32'(level), q.size());
      chk("full", 32'(full), 32'(q.size() == D));
      chk("ovf", 32'(overflow), 32'(of_m));
    end
  end

  initial begin
    repeat (3) tick();
    rst = 0;
    repeat (4) tick();
    chk("idle_level", 32'(level), 0);
    chk("idle_valid", 32'(out_valid), 0);
    chk("idle_char", 32'(out_char), 0);
    wr_strobe = 0;
    repeat (4) tick();
    wr_char = 8'h48;
    wr_strobe = 1;
    for (int i = 1; i <= N + 2; i++) begin
      tick();
      if (i == N + 1) chk("lat_early", 32'(out_valid), 0);
    end
    chk("lat_valid", 32'(out_valid), 1);
    chk("lat_char", 32'(out_char), 32'h48);
    chk("lat_level", 32'(level), 1);
    repeat (6) tick();
    wr_strobe = 0;
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("pop_valid", 32'(out_valid), 0);
    chk("pop_level", 32'(level), 0);
    repeat (4) tick();
    foreach (hello[i]) send(hello[i]);
    chk("hello_level", 32'(level), 5);
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      chk("hello_valid", 32'(out_valid), 1);
      chk("hello_char", 32'(out_char), 32'(hello[i]));
      tick();
    end
    out_ready = 0;
    chk("hello_empty", 32'(level), 0);
    for (int k = 0; k < 17; k++) begin
      send(8'(k));
      if (k == 15) begin
        chk("full16", 32'(full), 1);
        chk("no_ovf16", 32'(overflow), 0);
      end
    end
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_level", 32'(level), 16);
    out_ready = 1;
    for (int k = 0; k < 16; k++) begin
      chk("ovf_char", 32'(out_char), k);
      tick();
    end
    out_ready = 0;
    chk("ovf_sticky", 32'(overflow), 1);
    rst = 1;
    tick();
    rst = 0;
    repeat (4) tick();
    for (int k = 0; k < 16; k++) send(8'(8'h20 + k));
    chk("sim_full", 32'(full), 1);
    wr_char = 8'hAA;
    wr_strobe = 1;
    tick();
    tick();
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("sim_level", 32'(level), 16);
    chk("sim_ovf", 32'(overflow), 0);
    tick();
    wr_strobe = 0;
    repeat (4) tick();
    out_ready = 1;
    for (int k = 0; k < 16; k++) begin
      chk("sim_char", 32'(out_char), k < 15 ? 32'h21 + k : 32'hAA);
      tick();
    end
    out_ready = 0;
    rnd = 1;
    for (int k = 0; k < 40; k++) send(8'($urandom));
    rnd = 0;
    out_ready = 1;
    repeat (20) tick();
    out_ready = 0;
    chk("wrap_empty", 32'(level), 0);
    for (int k = 0; k < 7; k++) send(8'(8'h60 + k));
    chk("pre_rst_level", 32'(level), 7);
    #2 rst = 1;
    #1;
    chk("async_level", 32'(level), 0);
    chk("async_valid", 32'(out_valid), 0);
    chk("async_char", 32'(out_char), 0);
    chk("async_full", 32'(full), 0);
    tick();
    rst = 0;
    repeat (4) tick();
    send(8'h5A);
    chk("post_rst_valid", 32'(out_valid), 1);
    chk("post_rst_char", 32'(out_char), 32'h5A);
    chk("post_rst_level", 32'(level), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/bf_char_fifo.md
# bf_char_fifo

Output character buffer between the Brainfuck core's output strobe and the UART serialiser. It detects each output event from the slow core (a level strobe held for many `clk` cycles) and captures the character into a FIFO. It then presents the characters one at a time over a valid/ready handshake, so back-to-back `.` instructions are never lost while the serialiser is busy. The block runs entirely on the fast board clock `clk`.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, 2..256.
- `SYNC_STAGES`, 2: synchroniser flops on `wr_strobe`; minimum 2.

Ports:
- `clk`  in  1: board clock; all state on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `wr_strobe`  in  1: output-event level (core clock AND output flag); may be asynchronous to `clk`.
- `wr_char`  in  8: character to emit; stable from `wr_strobe` rise until its fall.
- `out_char`  out  8: head-of-queue character.
- `out_valid`  out  1: `out_char` holds a queued character.
- `out_ready`  in  1: consumer accepts head this cycle.
- `level`  out  $clog2(DEPTH)+1: entries currently stored.
- `full`  out  1: `level == DEPTH`.
- `overflow`  out  1: sticky; a character was dropped.

## Operation
- Reset values: `out_char` = 8'h00, `out_valid` = 0, `level` = 0, `full` = 0, `overflow` = 0.
- Reset clears the read pointer, write pointer and count. Storage contents are not cleared.
- Every synchroniser flop resets to 1. A strobe already high at reset release therefore produces no write.
- Edge detect: `push_req` is a one-cycle pulse when the last synchroniser stage is 1 and its previous value was 0.
- Exactly one push request is made per strobe high period. Glitch-free strobe is required upstream.
- `wr_char` is sampled in the `push_req` cycle and is not registered earlier.
- Pop occurs when `out_valid && out_ready`.
- Queue rules:
  - push, not full: write at `wptr`, then `wptr+1`, then `level+1`.
  - pop, not empty: `rptr+1`, then `level-1`.
  - push and pop in the same cycle, with `level` in 1..DEPTH: both occur and `level` is unchanged. When full, this push succeeds.
  - push, full, no pop: character is dropped and `overflow` is set. `overflow` clears only on `rst`.
  - push, empty: written normally. There is no bypass, and `out_valid` stays 0 that cycle.
  - pop while empty: impossible, because `out_valid` = 0.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- `level` is a separate counter, so full and empty are distinguishable.
- First-word-fall-through: `out_char` is driven from the registered read data of `mem[rptr]`.
- `out_valid` = (`level` != 0), registered.
- `out_char` may change only on a pop or on an empty-to-non-empty transition. It holds its last value while empty.

## Timing
- Strobe to `push_req`: SYNC_STAGES+1 `clk` cycles after the rising edge of `wr_strobe` first meets setup.
- `push_req` to `out_valid` (empty queue): 1 cycle. `out_char` is valid in that same cycle.
- Pop to next head: the next character appears on `out_char` the cycle after the pop, with no bubble while `level` > 1.
- Sustained throughput: one pop per cycle. Push rate is bounded by the strobe rate.
- `level`, `full` and `overflow` update 1 cycle after the causing event.
- Reset mid-operation: all outputs return to reset values asynchronously. In-flight strobe edges are discarded.

## Structure
- Shared package `bf_pkg`:
  - `char_t` (logic [7:0]).
  - `BF_FIFO_DEPTH` = 16 default.
  - `BF_SYNC_STAGES` = 2.
- Sub-module `strobe_edge_sync`: parameterised N-flop synchroniser with reset-to-1 and rising-edge pulse output. It is reusable for other slow-clock event crossings.
- Storage: plain register array inferred as distributed RAM, with registered read.

## Test plan
- Reset and idle:
  - Assert `rst` with `wr_strobe` = 1, then release.
  - Required: no push, `level` = 0, `out_valid` = 0, `out_char` = 8'h00.
- Single char:
  - Pulse `wr_strobe` high for 10 cycles with `wr_char` = 8'h48.
  - Required: `out_valid` rises exactly SYNC_STAGES+2 cycles after the strobe edge, with `out_char` = 8'h48 and `level` = 1.
  - Then pulse `out_ready` for 1 cycle. Required: `out_valid` = 0 and `level` = 0.
- Burst and order:
  - With `out_ready` = 0, send "Hello" (8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F).
  - Then hold `out_ready` = 1. Required: the same 5 bytes come out in order, one per cycle, and `level` goes 5→0.
- Full and overflow:
  - With `out_ready` = 0, send 17 strobes carrying 8'h00..8'h10.
  - Required: `full` = 1 after the 16th, the 17th is dropped, and `overflow` = 1 and stays set.
  - On draining, the output is 8'h00..8'h0F.
- Simultaneous push/pop at full:
  - With `level` = 16 and `out_ready` = 1, time a push into the same cycle as the pop.
  - Required: `level` stays 16, `overflow` stays 0, and the new byte appears last.
- Wrap-around and reset:
  - Push and pop 40 characters with random `out_ready`. Required: exact order preserved across pointer wrap.
  - Assert `rst` with `level` = 7. Required: all outputs reset immediately and the next character emitted is the first one pushed after release.
